// File: rtl/spi_master_regif.sv
// SPI mode-0 register-access initiator: one write or read frame per request.
// Optional SPI_MASTER_WVERIFY_EN: each write is followed by a readback frame, mismatch flagged on rsp_err.
module spi_master_regif #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FB = 8 + REG_W;
  localparam int HW = $clog2(2 * FB);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] LAST_EDGE = HW'(2 * FB - 1);
  localparam logic [HW-1:0] PRE_LAST  = HW'(2 * FB - 2);
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_END, S_GAP} state_t;

  function automatic logic [FB-1:0] build_frame(input logic wr, input logic [ADDR_W-1:0] a,
                                                input logic [REG_W-1:0] d);
    logic [7:0] cmd;
    cmd = '0;
    cmd[7] = wr;
    cmd[ADDR_W-1:0] = a;
    return {cmd, (wr ? d : {REG_W{1'b0}})};
  endfunction

  state_t            r_state;
  logic [DW-1:0]     r_div;
  logic [HW-1:0]     r_half;   // spi_clk edges seen in SHIFT; even = rising
  logic [FB-2:0]     r_tx;     // bits still to send after the one on MOSI
  logic              r_write;
  logic [REG_W-1:0]  r_rx;
  logic              r_rise_d;
  logic              r_sync1;
  logic              r_sync2;
  logic              w_div_end;
  logic              w_accept;
  logic [FB-1:0]     w_frame;

  assign w_div_end = (r_div == DIV_MAX);
  assign w_accept  = req_valid & req_ready & ena;
  assign w_frame   = build_frame(req_write, req_addr, req_wdata);

`ifdef SPI_MASTER_WVERIFY_EN
  logic [ADDR_W-1:0] r_addr;
  logic [REG_W-1:0]  r_wdata;
  logic              r_verify;
  logic [FB-1:0]     w_vframe;
  assign w_vframe = build_frame(1'b0, r_addr, {REG_W{1'b0}});
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_half    <= '0;
      r_tx      <= '0;
      r_write   <= 1'b0;
      r_rx      <= '0;
      r_rise_d  <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
`ifdef SPI_MASTER_WVERIFY_EN
      r_addr    <= '0;
      r_wdata   <= '0;
      r_verify  <= 1'b0;
`endif
    end else begin
      r_sync1   <= spi_miso;
      r_sync2   <= r_sync1;
      rsp_valid <= 1'b0;
      r_rise_d  <= 1'b0;
      // Sample one clk after each rising spi_clk so the synchroniser output has settled
      if (r_rise_d)
        r_rx <= {r_rx[REG_W-2:0], r_sync2};

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write   <= req_write;
            r_tx      <= w_frame[FB-2:0];
            spi_mosi  <= w_frame[FB-1];
            spi_cs_n  <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            r_div     <= '0;
            r_state   <= S_SETUP;
`ifdef SPI_MASTER_WVERIFY_EN
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_verify  <= 1'b0;
`endif
          end
        end

        S_SETUP: begin
          if (w_div_end) begin
            r_div    <= '0;
            r_half   <= '0;
            spi_clk  <= 1'b1;
            r_rise_d <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_half == LAST_EDGE) begin
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
`ifdef SPI_MASTER_WVERIFY_EN
              if (r_write && !r_verify) begin
                r_state <= S_GAP;
              end else begin
                r_state   <= S_END;
                rsp_valid <= 1'b1;
                rsp_rdata <= r_rx;
                rsp_err   <= r_write && (r_rx != r_wdata);
              end
`else
              r_state   <= S_END;
              rsp_valid <= 1'b1;
              if (!r_write)
                rsp_rdata <= r_rx;
`endif
            end else begin
              r_half  <= r_half + 1'b1;
              spi_clk <= ~spi_clk;
              if (spi_clk) begin
                if (r_half != PRE_LAST) begin
                  r_tx     <= {r_tx[FB-3:0], 1'b0};
                  spi_mosi <= r_tx[FB-2];
                end
              end else begin
                r_rise_d <= 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_END: begin
          r_div   <= '0;
          r_state <= S_GAP;
        end

        S_GAP: begin
          if (w_div_end) begin
            r_div <= '0;
`ifdef SPI_MASTER_WVERIFY_EN
            if (r_write && !r_verify) begin
              r_verify <= 1'b1;
              r_tx     <= w_vframe[FB-2:0];
              spi_mosi <= w_vframe[FB-1];
              spi_cs_n <= 1'b0;
              r_state  <= S_SETUP;
            end else begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_IDLE;
            end
`else
            req_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
`endif
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_regif.sv
// Directed bench for spi_master_regif (ADDR_W=3, REG_W=8, CLK_DIV=2) with a register-slave model.
module tb_spi_master_regif;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  int total = 0;
  int bad   = 0;

`ifdef SPI_MASTER_WVERIFY_EN
  localparam int WCS = 132;
  localparam int WRV = 135;
`else
  localparam int WCS = 66;
  localparam int WRV = 67;
`endif

  spi_master_regif #(.ADDR_W(3), .REG_W(8), .CLK_DIV(2)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // Register slave: captures MOSI on rising spi_clk, drives MISO on falling spi_clk
  logic [15:0] s_rx = '0;
  int          s_rcnt = 0;
  logic [7:0]  s_mem [8];
  logic [7:0]  s_out = '0;
  bit          s_stuck = 1'b0;
  logic [15:0] s_hist [$];

  always @(negedge spi_cs_n) begin
    s_rcnt = 0;
    s_rx   = '0;
  end

  always @(posedge spi_clk) begin
    s_rx = {s_rx[14:0], spi_mosi};
    s_rcnt++;
    if (s_rcnt == 8)
      s_out = s_stuck ? 8'h00 : s_mem[s_rx[2:0]];
  end

  always @(negedge spi_clk) begin
    if (spi_cs_n === 1'b0 && s_rcnt >= 8 && s_rcnt < 16)
      spi_miso = s_out[15 - s_rcnt];
  end

  always @(posedge spi_cs_n) begin
    if (s_rcnt == 16) begin
      if (s_rx[15])
        s_mem[s_rx[10:8]] = s_rx[7:0];
      s_hist.push_back(s_rx);
    end
    s_rcnt   = 0;
    spi_miso = 1'b0;
  end

  task automatic run_req(input logic wr, input logic [2:0] a, input logic [7:0] d, input int ena_drop,
                         output int cs_low, output int rv_cyc, output int rv_cnt, output int rdy_cyc,
                         output logic [7:0] rd, output logic er);
    cs_low = 0; rv_cyc = 0; rv_cnt = 0; rdy_cyc = 0; rd = '0; er = 1'b0;
    s_hist.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == ena_drop) ena = 1'b0;
      if (spi_cs_n === 1'b0) cs_low++;
      if (rsp_valid === 1'b1) begin
        rv_cnt++;
        if (rv_cyc == 0) rv_cyc = n;
        rd = rsp_rdata;
        er = rsp_err;
      end
      if (req_ready === 1'b1) begin
        rdy_cyc = n;
        break;
      end
    end
    ena = 1'b1;
  endtask

  task automatic test_reset;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, busy, spi_cs_n, spi_clk, spi_mosi} !== 15'b1_0_00000000_0_0_1_0_0) begin
      bad++;
      $display("FAIL reset_values: got %b want %b",
               {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, spi_cs_n, spi_clk, spi_mosi}, 15'b1_0_00000000_0_0_1_0_0);
    end
  endtask

  task automatic test_read;
    logic [2:0] ra [2] = '{3'd5, 3'd7};
    logic [7:0] rv [2] = '{8'h3C, 8'h81};
    int cs_low, rv_cyc, rv_cnt, rdy;
    logic [7:0] rd;
    logic er;
    s_mem[5] = 8'h3C;
    s_mem[7] = 8'h81;
    for (int i = 0; i < 2; i++) begin
      run_req(1'b0, ra[i], 8'hFF, 0, cs_low, rv_cyc, rv_cnt, rdy, rd, er);
      total++;
      if (s_hist.size() != 1 || s_hist[0] !== {5'b0, ra[i], 8'h00}) begin
        bad++; $display("FAIL read_mosi[%0d]: got %h (frames %0d) want %h", i, (s_hist.size() > 0) ? s_hist[0] : 16'hxxxx, s_hist.size(), {5'b0, ra[i], 8'h00});
      end
      total++;
      if (rd !== rv[i]) begin bad++; $display("FAIL read_data[%0d]: got %h want %h", i, rd, rv[i]); end
      total++;
      if (er !== 1'b0) begin bad++; $display("FAIL read_err[%0d]: got %b want 0", i, er); end
      total++;
      if (cs_low != 66 || rv_cyc != 67 || rv_cnt != 1 || rdy != 70) begin
        bad++; $display("FAIL read_timing[%0d]: cs_low=%0d rsp_at=%0d rsp_n=%0d ready_at=%0d want 66/67/1/70", i, cs_low, rv_cyc, rv_cnt, rdy);
      end
    end
  endtask

  task automatic test_write;
    logic [2:0]  wa [2] = '{3'd3, 3'd0};
    logic [7:0]  wd [2] = '{8'hA5, 8'hFF};
    logic [15:0] wf [2] = '{16'h83A5, 16'h80FF};
    int cs_low, rv_cyc, rv_cnt, rdy;
    logic [7:0] rd, exp_rd;
    logic er;
    for (int i = 0; i < 2; i++) begin
      run_req(1'b1, wa[i], wd[i], 0, cs_low, rv_cyc, rv_cnt, rdy, rd, er);
`ifdef SPI_MASTER_WVERIFY_EN
      exp_rd = wd[i];
`else
      exp_rd = 8'h81;
`endif
      total++;
      if (s_hist.size() < 1 || s_hist[0] !== wf[i]) begin
        bad++; $display("FAIL write_mosi[%0d]: got %h want %h", i, (s_hist.size() > 0) ? s_hist[0] : 16'hxxxx, wf[i]);
      end
      total++;
      if (s_mem[wa[i]] !== wd[i]) begin bad++; $display("FAIL write_slave[%0d]: got %h want %h", i, s_mem[wa[i]], wd[i]); end
      total++;
      if (cs_low != WCS || rv_cyc != WRV || rv_cnt != 1 || rdy != WRV + 3) begin
        bad++; $display("FAIL write_timing[%0d]: cs_low=%0d rsp_at=%0d rsp_n=%0d ready_at=%0d want %0d/%0d/1/%0d", i, cs_low, rv_cyc, rv_cnt, rdy, WCS, WRV, WRV + 3);
      end
      total++;
      if (rd !== exp_rd || er !== 1'b0) begin
        bad++; $display("FAIL write_rsp[%0d]: rdata=%h err=%b want %h/0", i, rd, er, exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back;
    int r1 = 0, nrsp = 0, first_rdy = 0, min_hi = 1000, hi_run = 0, rdy_bad = 0;
    bit seen_low = 1'b0;
    s_hist.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 8'h11;
    for (int n = 1; n <= 800; n++) begin
      @(negedge clk);
      if (n == 1) begin req_addr = 3'd2; req_wdata = 8'h22; end
      if (spi_cs_n === 1'b0) begin
        if (seen_low && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
        hi_run = 0;
        seen_low = 1'b1;
        if (req_ready !== 1'b0) rdy_bad++;
      end else if (seen_low) begin
        hi_run++;
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (nrsp == 1) r1 = n;
      end
      if (nrsp == 1 && first_rdy == 0 && req_ready === 1'b1) first_rdy = n;
      if (first_rdy != 0 && req_ready === 1'b0) req_valid = 1'b0;
      if (nrsp == 2 && req_ready === 1'b1) break;
    end
    req_valid = 1'b0;
    total++;
    if (nrsp != 2 || first_rdy - r1 != 3) begin
      bad++; $display("FAIL b2b_ready_gap: rsp_n=%0d gap=%0d want 2/3", nrsp, first_rdy - r1);
    end
    total++;
    if (min_hi < 2) begin bad++; $display("FAIL b2b_cs_gap: got %0d want >=2", min_hi); end
    total++;
    if (rdy_bad != 0) begin bad++; $display("FAIL b2b_ready_in_frame: got %0d cycles want 0", rdy_bad); end
    total++;
    if (s_hist.size() < 1 || s_hist[0] !== 16'h8111 || s_mem[1] !== 8'h11 || s_mem[2] !== 8'h22) begin
      bad++; $display("FAIL b2b_data: mem1=%h mem2=%h want 11/22", s_mem[1], s_mem[2]);
    end
  endtask

  task automatic test_ena;
    int viol = 0;
    int cs_low, rv_cyc, rv_cnt, rdy;
    logic [7:0] rd;
    logic er;
    @(negedge clk);
    ena = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5;
    repeat (50) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) viol++;
    end
    req_valid = 1'b0;
    ena = 1'b1;
    total++;
    if (viol != 0) begin bad++; $display("FAIL ena_block: got %0d active cycles want 0", viol); end
    run_req(1'b0, 3'd5, 8'h00, 10, cs_low, rv_cyc, rv_cnt, rdy, rd, er);
    total++;
    if (rv_cnt != 1 || rv_cyc != 67 || rd !== 8'h3C) begin
      bad++; $display("FAIL ena_midframe: rsp_n=%0d rsp_at=%0d rdata=%h want 1/67/3c", rv_cnt, rv_cyc, rd);
    end
  endtask

  task automatic test_abort;
    int found = 0, stray = 0;
    int cs_low, rv_cyc, rv_cnt, rdy;
    logic [7:0] rd;
    logic er;
    s_mem[6] = 8'hC3;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_rcnt == 7) begin found = 1; break; end
    end
    rstb = 1'b0;
    #1;
    total++;
    if (found == 0 || spi_cs_n !== 1'b1 || spi_clk !== 1'b0) begin
      bad++; $display("FAIL abort_async: found=%0d cs_n=%b sclk=%b want 1/1/0", found, spi_cs_n, spi_clk);
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || spi_cs_n !== 1'b1) stray++;
    end
    total++;
    if (stray != 0 || rsp_rdata !== 8'h00 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_quiet: stray=%0d rdata=%h ready=%b busy=%b want 0/00/1/0", stray, rsp_rdata, req_ready, busy);
    end
    run_req(1'b0, 3'd6, 8'h00, 0, cs_low, rv_cyc, rv_cnt, rdy, rd, er);
    total++;
    if (rd !== 8'hC3 || rv_cnt != 1 || rv_cyc != 67) begin
      bad++; $display("FAIL abort_reread: rdata=%h rsp_n=%0d rsp_at=%0d want c3/1/67", rd, rv_cnt, rv_cyc);
    end
  endtask

`ifdef SPI_MASTER_WVERIFY_EN
  task automatic test_verify;
    int cs_low, rv_cyc, rv_cnt, rdy;
    logic [7:0] rd;
    logic er;
    run_req(1'b1, 3'd2, 8'h5A, 0, cs_low, rv_cyc, rv_cnt, rdy, rd, er);
    total++;
    if (s_hist.size() != 2 || s_hist[0] !== 16'h825A || s_hist[1] !== 16'h0200) begin
      bad++; $display("FAIL verify_frames: got %0d frames want 2 (825a, 0200)", s_hist.size());
    end
    total++;
    if (rd !== 8'h5A || er !== 1'b0 || rv_cnt != 1 || rv_cyc != 135) begin
      bad++; $display("FAIL verify_ok: rdata=%h err=%b rsp_n=%0d rsp_at=%0d want 5a/0/1/135", rd, er, rv_cnt, rv_cyc);
    end
    s_stuck = 1'b1;
    run_req(1'b1, 3'd4, 8'h77, 0, cs_low, rv_cyc, rv_cnt, rdy, rd, er);
    s_stuck = 1'b0;
    total++;
    if (rd !== 8'h00 || er !== 1'b1 || rv_cnt != 1) begin
      bad++; $display("FAIL verify_stuck: rdata=%h err=%b rsp_n=%0d want 00/1/1", rd, er, rv_cnt);
    end
  endtask
`endif

  initial begin
    foreach (s_mem[i]) s_mem[i] = 8'h00;
    rstb = 1'b0; ena = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_ena;
    test_abort;
`ifdef SPI_MASTER_WVERIFY_EN
    test_verify;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
